// File: rtl/bus_drive_if.sv
// bus_drive_if: handshake and bus signals between an upstream producer /
// arbiter side and the bus_drive_ctrl sequencer.
//   in_valid/in_data/in_ready : upstream word handshake
//   bus_req/bus_gnt           : arbiter request/grant
//   data_en/data_out          : tri-state driver enable and word
//   empty/full                : FIFO status
// master: producer/arbiter/driver side; slave: the sequencer itself.
interface bus_drive_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             bus_req;
  logic             bus_gnt;
  logic             data_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;

  modport master (
    output in_valid, in_data, bus_gnt,
    input  in_ready, bus_req, data_en, data_out, empty, full
  );

  modport slave (
    input  in_valid, in_data, bus_gnt,
    output in_ready, bus_req, data_en, data_out, empty, full
  );
endinterface

// File: rtl/bus_drive_ctrl.sv
// bus_drive_ctrl: buffers upstream words in a small FIFO, requests the shared
// bus, drives bursts of up to MAX_BURST words while granted, then idles the
// bus for TURN cycles before it may request again.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bus_drive_if.slave (handshake, arbiter, driver and status signals)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus released, waiting for buffered data
// ST_REQ   | bus_req high, waiting for bus_gnt
// ST_DRIVE | data_en high, one FIFO word popped and driven per cycle
// ST_GAP   | bus released, TURN turnaround cycles before next request
module bus_drive_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int TURN      = 1
) (
  input  logic      clk,
  input  logic      rst,
  bus_drive_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int GW = $clog2(TURN + 1);

  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(TURN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [BW-1:0]    burst_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             push, pop;
  logic             driving;

  assign bus.in_ready = (count < DEPTH_C);
  assign bus.empty    = (count == '0);
  assign bus.full     = (count == DEPTH_C);

  assign push    = bus.in_valid && bus.in_ready;
  assign driving = (state == ST_DRIVE);
  assign pop     = driving;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // The burst ends on the cycle the FIFO would run dry (counting a
  // concurrent push) or when the burst length limit is reached.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (count != '0) state_nxt = ST_REQ;
      ST_REQ:   if (bus.bus_gnt) state_nxt = ST_DRIVE;
      ST_DRIVE: if (count_nxt == '0 || burst_cnt == BURST_LAST) state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;

      if (state == ST_REQ && bus.bus_gnt) burst_cnt <= '0;
      else if (driving)                   burst_cnt <= burst_cnt + 1'b1;

      // gap_cnt is a down-counter; GAP exits when it reaches zero, so
      // loading TURN-1 yields exactly TURN idle cycles.
      if (driving && state_nxt == ST_GAP)        gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Outputs decode only registered state and storage; a DRIVE cycle always
  // has count >= 1, so the head entry has been written.
  assign bus.data_en  = driving;
  assign bus.bus_req  = (state == ST_REQ) || driving;
  assign bus.data_out = driving ? mem[rd_ptr] : '0;

endmodule
